i2s_controller: RTL and testbench

I2S_CONTROLLER -- requirements
Module: i2s_controller

---
 rtl/i2s_controller.sv | 80 ++++++++
 tb/tb_i2s_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_controller.sv
// I2S transmitter: 16-bit stereo, 32 bit_clk slots per frame, registered outputs.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing instead of standard I2S.
module i2s_controller #(
    parameter int BCLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_left,
    input  logic [15:0] sample_right,
    output logic        bit_clk,
    output logic        frame_clk,
    output logic        data
);

    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam logic [4:0] LATCH_SLOT = 5'd0;
`else
    // Standard I2S: one-slot delay after the word-select edge.
    localparam logic [4:0] LATCH_SLOT = 5'd1;
`endif

    logic [DW-1:0] div_q;
    logic [4:0]    slot_q;
    logic [4:0]    slot_nx;
    logic [31:0]   sr_q;
    logic          tick;
    logic          fall;
    logic          latch;

    assign tick    = (div_q == DIV_LAST);
    assign fall    = tick & bit_clk;
    assign slot_nx = slot_q + 5'd1;
    assign latch   = fall & (slot_nx == LATCH_SLOT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_clk <= 1'b0;
        end else if (tick) begin
            bit_clk <= ~bit_clk;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q    <= 5'd31;
            frame_clk <= 1'b1;
        end else if (fall) begin
            slot_q    <= slot_nx;
            frame_clk <= slot_nx[4];
        end
    end

    // The MSB goes straight to data on the latch edge; the register keeps the rest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
            data <= 1'b0;
        end else if (latch) begin
            sr_q <= {sample_left[14:0], sample_right, 1'b0};
            data <= sample_left[15];
        end else if (fall) begin
            sr_q <= {sr_q[30:0], 1'b0};
            data <= sr_q[31];
        end
    end

endmodule

// File: tb/tb_i2s_controller.sv
// Self-checking bench for i2s_controller (BCLK_DIV = 2), both framing modes.
module tb_i2s_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] sample_left = '0;
    logic [15:0] sample_right = '0;
    logic        bit_clk;
    logic        frame_clk;
    logic        data;

    i2s_controller #(.BCLK_DIV(2)) dut (
        .clk(clk),
        .reset(reset),
        .sample_left(sample_left),
        .sample_right(sample_right),
        .bit_clk(bit_clk),
        .frame_clk(frame_clk),
        .data(data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] mask;
    } vec_t;

    typedef struct {
        logic [4:0] slot;
        logic       fclk;
        logic       d;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam logic [4:0] START = 5'd0;
    localparam logic [31:0] HOLD_MASK = 32'h0000FFFF;
`else
    localparam logic [4:0] START = 5'd1;
    localparam logic [31:0] HOLD_MASK = 32'h0001FFFE;
`endif

    // Receiver view: slot tracking and capture at each bit_clk rise.
    logic       prev_b = 1'b0;
    logic [4:0] tb_slot = 5'd31;
    logic [4:0] s_slot = '0;
    logic       s_f = 1'b0;
    logic       s_d = 1'b0;
    int         rise_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_b  <= 1'b0;
            tb_slot <= 5'd31;
        end else begin
            prev_b <= bit_clk;
            if (prev_b && !bit_clk)
                tb_slot <= tb_slot + 5'd1;
            if (!prev_b && bit_clk) begin
                s_slot   <= tb_slot;
                s_f      <= frame_clk;
                s_d      <= data;
                rise_cnt <= rise_cnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic next_rise();
        int start;
        int n;
        start = rise_cnt;
        n = 0;
        while (rise_cnt == start && n < 64) begin
            @(posedge clk);
            n++;
        end
        if (rise_cnt == start) begin
            total++;
            bad++;
            $display("FAIL rise_timeout actual=none required=bit_clk_rise");
        end
    endtask

    task automatic wait_slot(input logic [4:0] s);
        int k;
        k = 0;
        do begin
            next_rise();
            k++;
        end while (s_slot != s && k < 40);
        if (s_slot != s) begin
            total++;
            bad++;
            $display("FAIL slot_timeout actual=%0d required=%0d", s_slot, s);
        end
    endtask

    task automatic push_frame(input logic [31:0] mask);
        logic [4:0] sl;
        for (int i = 0; i < 32; i++) begin
            sl = START + 5'(i);
            sb.push_back('{sl, sl[4], mask[sl]});
        end
    endtask

    // First entry matches the rise already captured.
    task automatic drain(input int chg_slot, input logic [15:0] nl,
                         input logic [15:0] nr);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("slot", 32'(s_slot), 32'(e.slot));
            chk("frame_clk", 32'(s_f), 32'(e.fclk));
            chk($sformatf("data_slot%0d", e.slot), 32'(s_d), 32'(e.d));
            if (int'(s_slot) == chg_slot) begin
                sample_left  = nl;
                sample_right = nr;
            end
            if (sb.size() > 0)
                next_rise();
        end
    endtask

    task automatic release_check(input string tag);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_bclk_k%0d", tag, k), 32'(bit_clk),
                32'((k == 2) || (k == 3)));
        end
        chk({tag, "_fclk_slot0"}, 32'(frame_clk), 32'd0);
        chk({tag, "_data_slot0"}, 32'(data), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bclk"}, 32'(bit_clk), 32'd0);
        chk({tag, "_fclk"}, 32'(frame_clk), 32'd1);
        chk({tag, "_data"}, 32'(data), 32'd0);
    endtask

    task automatic measure_timing();
        logic p;
        int n;
        n = 0;
        do begin
            p = bit_clk;
            @(posedge clk);
            #1;
            n++;
        end while (!(!p && bit_clk) && n < 20);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bit_clk && n < 20);
        chk("bclk_high", 32'(n), 32'd2);
        do begin
            p = bit_clk;
            @(posedge clk);
            #1;
            n++;
        end while (!(!p && bit_clk) && n < 40);
        chk("bclk_period", 32'(n), 32'd4);
        n = 0;
        do begin
            p = frame_clk;
            @(posedge clk);
            #1;
            n++;
        end while (!(p && !frame_clk) && n < 300);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_clk && n < 300);
        chk("fclk_low", 32'(n), 32'd64);
        p = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (frame_clk && n < 400);
        chk("frame_len", 32'(n), 32'd128);
        chk("fclk_high", 32'(n - 64), 32'd64);
    endtask

    initial begin
`ifdef I2S_LEFT_JUSTIFIED_EN
        vecs[0] = '{16'h0011, 16'h0011, 32'h88008800};
        vecs[1] = '{16'h0000, 16'h8001, 32'h80010000};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 32'hFFFFFFFF};
        vecs[3] = '{16'h8000, 16'h0000, 32'h00000001};
        vecs[4] = '{16'h0001, 16'h0000, 32'h00008000};
        vecs[5] = '{16'h0000, 16'h0001, 32'h80000000};
`else
        vecs[0] = '{16'h0011, 16'h0011, 32'h10011001};
        vecs[1] = '{16'h0000, 16'h8001, 32'h00020001};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 32'hFFFFFFFF};
        vecs[3] = '{16'h8000, 16'h0000, 32'h00000002};
        vecs[4] = '{16'h0001, 16'h0000, 32'h00010000};
        vecs[5] = '{16'h0000, 16'h0001, 32'h00000001};
`endif

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst_hold");
        release_check("rel");
        measure_timing();

        for (int i = 0; i < 6; i++) begin
            sample_left  = vecs[i].l;
            sample_right = vecs[i].r;
            push_frame(vecs[i].mask);
            wait_slot(START);
            drain(-1, '0, '0);
        end

        // Sample change mid-frame must not disturb the latched frame.
        sample_left  = 16'hFFFF;
        sample_right = 16'h0000;
        push_frame(HOLD_MASK);
        wait_slot(START);
        drain(5, 16'h0000, 16'h0000);
        push_frame(32'h0);
        next_rise();
        drain(-1, '0, '0);

        // Reset asserted mid-frame.
        sample_left  = 16'h0000;
        sample_right = 16'hFFFF;
        wait_slot(5'd20);
        chk("pre_reset_data", 32'(s_d), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("mid_rst_hold");
        release_check("rerel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
